// File: rtl/uk101_video_pkg.sv
// uk101_video_pkg: shared fetch states, default video timing and glyph geometry
package uk101_video_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, ROM, LATCH} fetch_t;
  localparam int H_TOTAL_DEF    = 494;
  localparam int H_ACTIVE_DEF   = 384;
  localparam int HS_START_DEF   = 416;
  localparam int HS_LEN_DEF     = 36;
  localparam int V_TOTAL_DEF    = 312;
  localparam int V_ACTIVE_DEF   = 256;
  localparam int VS_START_DEF   = 280;
  localparam int VS_LEN_DEF     = 4;
  localparam int COL_OFFSET_DEF = 13;
  localparam int GLYPH_W        = 8;
  localparam int LINE_SHIFT     = 1;
  localparam int DELAY          = 8;
  localparam logic [3:0] OUT_IDLE = 4'b0011;
endpackage

// File: rtl/uk101_video_timing.sv
// uk101_video_timing: pixel/line counters, raw sync/blank decode and the pixel-alignment delay
module uk101_video_timing
  import uk101_video_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_LEN   = HS_LEN_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_LEN   = VS_LEN_DEF
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ce_pix,
  output logic [8:0] h_cnt,
  output logic [3:0] row,
  output logic [2:0] glyph_line,
  output logic       hb_raw,
  output logic       vb_raw,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank
);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_START + HS_LEN);
  localparam logic [8:0] VS_S   = 9'(VS_START);
  localparam logic [8:0] VS_E   = 9'(VS_START + VS_LEN);
  logic [8:0] v_cnt;
  logic hs_raw, vs_raw;
  logic [DELAY-1:0][3:0] dly;
  assign hs_raw = (h_cnt >= HS_S) && (h_cnt < HS_E);
  assign vs_raw = (v_cnt >= VS_S) && (v_cnt < VS_E);
  assign hb_raw = h_cnt >= H_ACT;
  assign vb_raw = v_cnt >= V_ACT;
  assign glyph_line = v_cnt[LINE_SHIFT +: 3];
  assign row = v_cnt[LINE_SHIFT + 3 +: 4];
  // Raster counters: pixel counter wraps into the line counter, both only on ce_pix
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce_pix) begin
      h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 9'd1;
      if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 9'd1;
    end
  // Eight delay stages plus the output register match the fetch-and-shift latency of the pixel path
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      dly <= {DELAY{OUT_IDLE}};
      {hsync, vsync, hblank, vblank} <= OUT_IDLE;
    end else if (ce_pix) begin
      dly <= {dly[DELAY-2:0], {hs_raw, vs_raw, hb_raw, vb_raw}};
      {hsync, vsync, hblank, vblank} <= dly[DELAY-1];
    end
endmodule

// File: rtl/uk101_video_gen.sv
// uk101_video_gen: 48x16 character display generator with glyph fetch and pixel serializer
module uk101_video_gen
  import uk101_video_pkg::*;
#(
  parameter int H_TOTAL    = H_TOTAL_DEF,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int HS_START   = HS_START_DEF,
  parameter int HS_LEN     = HS_LEN_DEF,
  parameter int V_TOTAL    = V_TOTAL_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int VS_START   = VS_START_DEF,
  parameter int VS_LEN     = VS_LEN_DEF,
  parameter int COL_OFFSET = COL_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ce_pix,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] charrom_addr,
  input  logic [7:0]  charrom_data,
  output logic        video,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank
);
  localparam int GB = $clog2(GLYPH_W);
  localparam logic [5:0] COL_OFF = 6'(COL_OFFSET);
  logic [8:0] h_cnt;
  logic [3:0] row;
  logic [2:0] glyph_line;
  logic hb_raw, vb_raw, cell_start;
  fetch_t state;
  logic [7:0] hold, shift;
  assign cell_start = ce_pix && (h_cnt[GB-1:0] == '0);
  assign video = shift[7];
  uk101_video_timing #(
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START), .HS_LEN(HS_LEN),
    .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_LEN(VS_LEN)
  ) u_timing (
    .clk(clk), .n_reset(n_reset), .ce_pix(ce_pix), .h_cnt(h_cnt), .row(row),
    .glyph_line(glyph_line), .hb_raw(hb_raw), .vb_raw(vb_raw),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank)
  );
  // Fetch the next cell's glyph row in three clocks, well inside one pixel period
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      vram_addr <= '0;
      charrom_addr <= '0;
      hold <= '0;
    end else
      case (state)
        IDLE: if (cell_start) state <= ADDR;
        ADDR: begin
          vram_addr <= {row, h_cnt[GB +: 6] + COL_OFF};
          state <= ROM;
        end
        ROM: begin
          charrom_addr <= {vram_data, glyph_line};
          state <= LATCH;
        end
        default: begin
          hold <= (hb_raw || vb_raw) ? '0 : charrom_data;
          state <= IDLE;
        end
      endcase
  // Load the previously fetched glyph at each cell boundary, otherwise shift out MSB first
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) shift <= '0;
    else if (ce_pix) shift <= cell_start ? hold : {shift[6:0], 1'b0};
endmodule

// File: tb/tb_uk101_video_gen.sv
// tb_uk101_video_gen: randomized pixel-stream check against a raster-arithmetic reference model
module tb_uk101_video_gen;
  localparam int HT = 494, HA = 384, HSS = 416, HSL = 36;
  localparam int VT = 20, VA = 18, VSS = 18, VSL = 1;
  localparam int OFF = 13, OFF2 = 40;
  localparam int FRAME = HT * VT;
  logic clk = 1'b0, n_reset = 1'b1, ce_pix = 1'b0;
  logic [9:0] vram_addr, vram_addr2;
  logic [10:0] charrom_addr, charrom_addr2;
  logic [7:0] vram_data = '0, vram_data2 = '0, charrom_data = '0, charrom_data2 = '0;
  logic video, hsync, vsync, hblank, vblank;
  logic video2, hsync2, vsync2, hblank2, vblank2;
  logic [7:0] vmem [1024];
  logic [7:0] cmem [2048];
  int checks = 0, errors = 0, k = 0, hs_n = 0, vs_n = 0, vb_n = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    vram_data <= vmem[vram_addr];
    charrom_data <= cmem[charrom_addr];
    vram_data2 <= vmem[vram_addr2];
    charrom_data2 <= cmem[charrom_addr2];
  end

  uk101_video_gen #(.V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_LEN(VSL)) dut (
    .clk(clk), .n_reset(n_reset), .ce_pix(ce_pix),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .charrom_addr(charrom_addr), .charrom_data(charrom_data),
    .video(video), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank)
  );

  uk101_video_gen #(.V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_LEN(VSL), .COL_OFFSET(OFF2)) dut_off (
    .clk(clk), .n_reset(n_reset), .ce_pix(ce_pix),
    .vram_addr(vram_addr2), .vram_data(vram_data2),
    .charrom_addr(charrom_addr2), .charrom_data(charrom_data2),
    .video(video2), .hsync(hsync2), .vsync(vsync2), .hblank(hblank2), .vblank(vblank2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (strobe %0d)", tag, got, exp, k);
    end
  endtask

  // Outputs after strobe n show raster pixel n-8; earlier strobes show the reset state.
  function automatic logic [4:0] model_out(input int n);
    int p, h, v, col, rw, code;
    logic [7:0] g;
    if (n < 8) return 5'b00011;
    p = n - 8;
    h = p % HT;
    v = (p / HT) % VT;
    col = (h / 8 + OFF) % 64;
    rw = (v / 16) % 16;
    code = int'(vmem[rw * 64 + col]);
    g = cmem[code * 8 + (v / 2) % 8];
    return {(h < HA && v < VA) ? g[7 - h % 8] : 1'b0,
            1'(h >= HSS && h < HSS + HSL), 1'(v >= VSS && v < VSS + VSL),
            1'(h >= HA), 1'(v >= VA)};
  endfunction

  task automatic reset_check();
    check("rst_video", 32'(video), 0);
    check("rst_hsync", 32'(hsync), 0);
    check("rst_vsync", 32'(vsync), 0);
    check("rst_hblank", 32'(hblank), 1);
    check("rst_vblank", 32'(vblank), 1);
    check("rst_vram_addr", 32'(vram_addr), 0);
    check("rst_charrom_addr", 32'(charrom_addr), 0);
  endtask

  task automatic pix();
    int h, v, sp, ea, ea2;
    logic [4:0] e;
    h = k % HT;
    v = (k / HT) % VT;
    sp = $urandom_range(4, 6);
    e = model_out(k);
    ea = ((v / 16) % 16) * 64 + (h / 8 + OFF) % 64;
    ea2 = ((v / 16) % 16) * 64 + (h / 8 + OFF2) % 64;
    @(negedge clk) ce_pix = 1'b1;
    @(negedge clk) ce_pix = 1'b0;
    check("video", 32'(video), 32'(e[4]));
    check("hsync", 32'(hsync), 32'(e[3]));
    check("vsync", 32'(vsync), 32'(e[2]));
    check("hblank", 32'(hblank), 32'(e[1]));
    check("vblank", 32'(vblank), 32'(e[0]));
    check("blank_dark", 32'(video & (hblank | vblank)), 0);
    if (k >= 8 && k < 8 + FRAME) begin
      hs_n += 32'(hsync);
      vs_n += 32'(vsync);
      vb_n += 32'(vblank);
    end
    @(negedge clk);
    if (h % 8 == 0) begin
      check("vram_addr", 32'(vram_addr), 32'(ea));
      check("vram_addr_off40", 32'(vram_addr2), 32'(ea2));
      if (h == 0 && v == 0) check("first_fetch", 32'(vram_addr), 32'h00D);
      if (h == HA - 8 && v == 0) check("last_fetch", 32'(vram_addr), 32'h03C);
      if (h == 0 && v == 16) check("row1_fetch", 32'(vram_addr), 32'h04D);
      if (h == 240) check("col_wrap", 32'(vram_addr2), 32'(((v / 16) % 16) * 64 + 6));
    end
    @(negedge clk);
    if (h % 8 == 0) begin
      check("charrom_addr", 32'(charrom_addr), 32'(int'(vmem[ea]) * 8 + (v / 2) % 8));
      if (v == 17) check("line17_field", 32'(charrom_addr[2:0]), 0);
    end
    repeat (sp - 4) @(negedge clk);
    k++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) vmem[i] = ($urandom_range(0, 3) == 0) ? 8'h41 : 8'($urandom);
    for (int i = 0; i < 2048; i++) cmem[i] = 8'($urandom);
    for (int l = 0; l < 8; l++) cmem[8'h41 * 8 + l] = 8'h81;
    #1 n_reset = 1'b0;
    repeat (3) @(negedge clk);
    reset_check();
    n_reset = 1'b1;
    k = 0;
    for (int i = 0; i < FRAME + 5 * HT + 200; i++) pix();
    check("hsync_per_frame", 32'(hs_n), 32'(HSL * VT));
    check("vsync_per_frame", 32'(vs_n), 32'(VSL * HT));
    check("vblank_per_frame", 32'(vb_n), 32'((VT - VA) * HT));
    #2 n_reset = 1'b0;
    #1 reset_check();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    k = 0;
    for (int i = 0; i < 600; i++) pix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
